// File: rtl/latency_memory_dp.sv
// Dual-port latency memory model: port A instruction read, port B data read/write.
// Define RANDOM_STALL_EN to add 0-3 LFSR-driven extra wait cycles per transaction.
module latency_memory_dp #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH_W = 16,
    parameter int unsigned LAT_A   = 1,
    parameter int unsigned LAT_B   = 1,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                read_a,
    input  logic [31:0]         address_a,
    output logic                resp_a,
    output logic [DATA_W-1:0]   rdata_a,
    input  logic                read_b,
    input  logic                write,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic [31:0]         address_b,
    input  logic [DATA_W-1:0]   wdata,
    output logic                resp_b,
    output logic [DATA_W-1:0]   rdata_b,
    output logic                err_conflict,
    output logic                err_protocol
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned WORDS = 1 << DEPTH_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    logic [DATA_W-1:0] mem_q [WORDS];

    state_e             state_a_q, state_a_d, state_b_q, state_b_d;
    logic [31:0]        cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [31:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DATA_W-1:0]  wdata_b_q, wdata_b_d;
    logic [BYTES-1:0]   wmask_b_q, wmask_b_d;
    logic               we_b_q, we_b_d;
    logic               resp_a_q, resp_a_d, resp_b_q, resp_b_d;
    logic [DATA_W-1:0]  rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic               err_conflict_q, err_conflict_d, err_protocol_q, err_protocol_d;
    logic               prot_a, prot_b, conflict_b;
    logic [31:0]        stall;

    function automatic logic [DEPTH_W-1:0] word_idx(input logic [31:0] addr);
        return addr[DEPTH_W+OFF_W-1:OFF_W];
    endfunction

`ifdef RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall  = {30'b0, lfsr_q[1:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end
`else
    always_comb stall = '0;
`endif

    // Port A: rdata is sampled on the edge entering RESP, using the live address
    // when the transaction skips WAIT and the captured one otherwise.
    always_comb begin
        state_a_d = state_a_q;
        cnt_a_d   = cnt_a_q;
        addr_a_d  = addr_a_q;
        rdata_a_d = rdata_a_q;
        prot_a    = 1'b0;
        case (state_a_q)
            IDLE: if (read_a) begin
                addr_a_d  = address_a;
                cnt_a_d   = LAT_A - 1 + stall;
                state_a_d = (cnt_a_d == '0) ? RESP : WAIT;
            end
            WAIT: begin
                prot_a  = !read_a || (address_a != addr_a_q);
                cnt_a_d = cnt_a_q - 1;
                if (cnt_a_d == '0) state_a_d = RESP;
            end
            default: state_a_d = IDLE;
        endcase
        if (state_a_q != RESP && state_a_d == RESP) rdata_a_d = mem_q[word_idx(addr_a_d)];
        resp_a_d = (state_a_d == RESP);
    end

    always_comb begin
        state_b_d  = state_b_q;
        cnt_b_d    = cnt_b_q;
        addr_b_d   = addr_b_q;
        wdata_b_d  = wdata_b_q;
        wmask_b_d  = wmask_b_q;
        we_b_d     = we_b_q;
        rdata_b_d  = rdata_b_q;
        prot_b     = 1'b0;
        conflict_b = 1'b0;
        case (state_b_q)
            IDLE: begin
                conflict_b = read_b && write;
                if (read_b ^ write) begin
                    addr_b_d  = address_b;
                    wdata_b_d = wdata;
                    wmask_b_d = wmask;
                    we_b_d    = write;
                    cnt_b_d   = LAT_B - 1 + stall;
                    state_b_d = (cnt_b_d == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                prot_b  = (read_b != !we_b_q) || (write != we_b_q) || (address_b != addr_b_q);
                cnt_b_d = cnt_b_q - 1;
                if (cnt_b_d == '0) state_b_d = RESP;
            end
            default: state_b_d = IDLE;
        endcase
        if (state_b_q != RESP && state_b_d == RESP && !we_b_d)
            rdata_b_d = mem_q[word_idx(addr_b_d)];
        resp_b_d       = (state_b_d == RESP);
        err_conflict_d = err_conflict_q || conflict_b;
        err_protocol_d = err_protocol_q || prot_a || prot_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_a_q      <= IDLE;
            state_b_q      <= IDLE;
            cnt_a_q        <= '0;
            cnt_b_q        <= '0;
            addr_a_q       <= '0;
            addr_b_q       <= '0;
            wdata_b_q      <= '0;
            wmask_b_q      <= '0;
            we_b_q         <= 1'b0;
            resp_a_q       <= 1'b0;
            resp_b_q       <= 1'b0;
            rdata_a_q      <= '0;
            rdata_b_q      <= '0;
            err_conflict_q <= 1'b0;
            err_protocol_q <= 1'b0;
        end else begin
            state_a_q      <= state_a_d;
            state_b_q      <= state_b_d;
            cnt_a_q        <= cnt_a_d;
            cnt_b_q        <= cnt_b_d;
            addr_a_q       <= addr_a_d;
            addr_b_q       <= addr_b_d;
            wdata_b_q      <= wdata_b_d;
            wmask_b_q      <= wmask_b_d;
            we_b_q         <= we_b_d;
            resp_a_q       <= resp_a_d;
            resp_b_q       <= resp_b_d;
            rdata_a_q      <= rdata_a_d;
            rdata_b_q      <= rdata_b_d;
            err_conflict_q <= err_conflict_d;
            err_protocol_q <= err_protocol_d;
        end
    end

    // Write commits on the edge that ends RESP; a concurrent port A read already sampled old data.
    always_ff @(posedge clk) begin
        if (rst_n && state_b_q == RESP && we_b_q) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wmask_b_q[i]) mem_q[word_idx(addr_b_q)][i*8 +: 8] <= wdata_b_q[i*8 +: 8];
            end
        end
    end

    assign resp_a       = resp_a_q;
    assign rdata_a      = rdata_a_q;
    assign resp_b       = resp_b_q;
    assign rdata_b      = rdata_b_q;
    assign err_conflict = err_conflict_q;
    assign err_protocol = err_protocol_q;
endmodule
